vslc_sequencer: RTL and testbench
=================================

VSLC_SEQUENCER -- requirements
Module: vslc_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_DEPTH, default 32, meaning program memory depth in bytes (power of two, 4..64).
REQ-002 The block SHALL have port clk, input, 1, meaning system clock with all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning reset (synchronous, active-low).
REQ-004 The block SHALL have port mode_load, input, 1, meaning 1 = program-load mode with priority over run.
REQ-005 The block SHALL have port load_valid, input, 1, meaning load_data valid.
REQ-006 The block SHALL have port load_data, input, 8, meaning program byte.
REQ-007 The block SHALL have port load_ready, output, 1, meaning byte accepted when load_valid && load_ready.
REQ-008 The block SHALL have port run_en, input, 1, meaning continuous scan enable.
REQ-009 The block SHALL have port ui_in, input, 8, meaning raw inputs.
REQ-010 The block SHALL have port ui_in_snap, output, 8, meaning inputs latched at scan start.
REQ-011 The block SHALL have port ui_in_prev, output, 8, meaning snapshot from the previous scan.
REQ-012 The block SHALL have port instr, output, 8, meaning instruction byte to the executor.
REQ-013 The block SHALL have port instr_ready, output, 1, meaning instr valid for exactly one cycle.
REQ-014 The block SHALL have port pc, output, log2(PROG_DEPTH), meaning address of the current or last issued instruction.
REQ-015 The block SHALL have port prog_len, output, log2(PROG_DEPTH)+1, meaning number of loaded bytes.
REQ-016 The block SHALL have port scan_done, output, 1, meaning one-cycle pulse at end of scan.

Function
REQ-017 States SHALL be IDLE, LOAD, SCAN_START, ISSUE and SCAN_END.
REQ-018 From any state, mode_load=1 SHALL force LOAD next cycle, deassert instr_ready and clear pc.
REQ-019 Entering LOAD SHALL clear the write pointer.
REQ-020 In LOAD, load_ready SHALL be 1 iff write pointer < PROG_DEPTH.
REQ-021 Each accepted byte in LOAD SHALL be written to mem[write pointer] and the pointer incremented.
REQ-022 When the write pointer = PROG_DEPTH, further load_valid SHALL be ignored with no wrap.
REQ-023 LOAD→IDLE on mode_load=0; prog_len SHALL then be set to the write pointer in the same edge.
REQ-024 IDLE→SCAN_START SHALL occur when run_en=1, mode_load=0 and prog_len≠0.
REQ-025 With prog_len=0 the block SHALL stay in IDLE.
REQ-026 SCAN_START SHALL set ui_in_prev←ui_in_snap, ui_in_snap←ui_in and pc←0, then go to ISSUE.
REQ-027 ISSUE SHALL register instr=mem[pc] with instr_ready=1 for one cycle.
REQ-028 instr and instr_ready SHALL be registered outputs so they are stable across the following falling edge, where the executor samples.
REQ-029 In ISSUE, pc SHALL increment if pc<prog_len−1; otherwise the block SHALL go to SCAN_END.
REQ-030 SCAN_END SHALL pulse scan_done for one cycle, then go to SCAN_START if run_en=1, else IDLE.
REQ-031 Deasserting run_en mid-scan SHALL complete the current scan.
REQ-032 Latency SHALL be: run_en rising at cycle N gives SCAN_START at N+1 and the first instr_ready at N+2.
REQ-033 Scan period SHALL be prog_len+2 cycles.
REQ-034 instr_ready SHALL never be 1 outside ISSUE.

Reset
REQ-035 When rst_n=0 at a clock edge, state SHALL become IDLE and all outputs SHALL become 0: instr, instr_ready, pc, prog_len, ui_in_snap, ui_in_prev, scan_done and load_ready.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset mid-scan SHALL abort without a scan_done pulse.

Configuration
REQ-038 With VSLC_SEQ_STEP_EN defined, the block SHALL add input step (1 bit), and ISSUE SHALL hold (no instr_ready, pc unchanged) until a cycle with step=1, issuing exactly one instruction per step cycle.
REQ-039 With VSLC_SEQ_STEP_EN defined, SCAN_START and SCAN_END SHALL NOT wait for step.
REQ-040 Without VSLC_SEQ_STEP_EN, the step port SHALL be absent and the block SHALL free-run as in REQ-027..030.

Structure
REQ-041 Shared package vslc_pkg SHALL hold the state enum type and the default PROG_DEPTH constant.
REQ-042 Program storage SHALL be sub-module vslc_prog_mem, a 1-write / 1-read async-read register array.

Verification
REQ-043 Load bytes 0x01,0x80,0x10 then drop mode_load → prog_len=3, load_ready=0 in IDLE.
REQ-044 run_en=1 with that program → instr_ready pulses with 0x01,0x80,0x10 on cycles N+2..N+4, scan_done at N+5, next first issue at N+7.
REQ-045 ui_in=0x0F in scan 1, then 0xF0 in scan 2 → in scan 2 ui_in_snap=0xF0 and ui_in_prev=0x0F.
REQ-046 Load PROG_DEPTH+3 bytes → load_ready=0 after byte PROG_DEPTH, prog_len=PROG_DEPTH, extras not written.
REQ-047 mode_load=1 during the 2nd issue → no further instr_ready, pc=0, state LOAD next cycle; run_en=1 with prog_len=0 → no issue.
REQ-048 With VSLC_SEQ_STEP_EN, step held 0 for 10 cycles → no instr_ready; two step pulses → exactly two instructions issued.

Source files
------------

// File: rtl/vslc_pkg.sv
// rtl/vslc_pkg.sv - shared types and constants for the VSLC sequencer
//
// Purpose: holds the sequencer state encoding and the default program depth.
// Configuration macro: none.

package vslc_pkg;

  localparam int VSLC_PROG_DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SCAN_START = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_SCAN_END   = 3'd4
  } vslc_state_e;

endpackage

// File: rtl/vslc_sequencer_if.sv
// rtl/vslc_sequencer_if.sv - load/run/executor signal bundle for the VSLC sequencer
//
// Purpose: groups the program-load handshake, scan control and executor-facing
// outputs of the sequencer.
// Modports:
//   master - the controller side: drives mode_load, load_valid, load_data,
//            run_en, ui_in (and step); observes everything else.
//   slave  - the sequencer itself.
// Configuration macro: VSLC_SEQ_STEP_EN adds the single-step input 'step'.

interface vslc_sequencer_if #(
  parameter int PROG_DEPTH = vslc_pkg::VSLC_PROG_DEPTH_DEFAULT
) ();

  localparam int AW = $clog2(PROG_DEPTH);

  logic          mode_load;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          run_en;
  logic [7:0]    ui_in;
  logic [7:0]    ui_in_snap;
  logic [7:0]    ui_in_prev;
  logic [7:0]    instr;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          scan_done;
`ifdef VSLC_SEQ_STEP_EN
  logic          step;
`endif

  modport master (
`ifdef VSLC_SEQ_STEP_EN
    output step,
`endif
    output mode_load, load_valid, load_data, run_en, ui_in,
    input  load_ready, ui_in_snap, ui_in_prev, instr, instr_ready,
    input  pc, prog_len, scan_done
  );

  modport slave (
`ifdef VSLC_SEQ_STEP_EN
    input  step,
`endif
    input  mode_load, load_valid, load_data, run_en, ui_in,
    output load_ready, ui_in_snap, ui_in_prev, instr, instr_ready,
    output pc, prog_len, scan_done
  );

endinterface

// File: rtl/vslc_sequencer_prog_mem.sv
// rtl/vslc_sequencer_prog_mem.sv - program byte store for the VSLC sequencer
//
// Purpose: 1-write / 1-read register array with asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write byte
//   raddr - read address
//   rdata - read byte (combinational from raddr)
// Contents are deliberately not reset.
// Configuration macro: none.

module vslc_prog_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vslc_sequencer.sv
// rtl/vslc_sequencer.sv - program loader and scan sequencer feeding an instruction executor
//
// Purpose: loads a byte program, then repeatedly scans it, snapshotting ui_in
// at each scan start and issuing one registered instruction per cycle.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - vslc_sequencer_if.slave: load handshake, run_en/ui_in, and the
//           instr/instr_ready/pc/prog_len/scan_done/snapshot outputs
// Configuration macro: VSLC_SEQ_STEP_EN - ISSUE waits for bus.step, one
// instruction per step cycle.

module vslc_sequencer
  import vslc_pkg::*;
#(
  parameter int PROG_DEPTH = VSLC_PROG_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  vslc_sequencer_if.slave bus
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(PROG_DEPTH);

  vslc_state_e   state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] prog_len_q, prog_len_d;
  logic [7:0]    snap_q, snap_d;
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    instr_q, instr_d;
  logic          instr_ready_q, instr_ready_d;
  logic          scan_done_q, scan_done_d;
`ifdef VSLC_SEQ_STEP_EN
  logic          done_q, done_d;
`endif

  logic          load_accept;
  logic          last_c;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  // Accept only while the pointer is below depth; a full buffer ignores
  // further bytes rather than wrapping.
  assign load_accept = (state_q == ST_LOAD) && bus.load_valid && (wptr_q < DEPTH_L);
  assign last_c      = (LW'(pc_q) + LW'(1)) >= prog_len_q;

  vslc_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (load_accept),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      wptr_q        <= '0;
      prog_len_q    <= '0;
      snap_q        <= '0;
      prev_q        <= '0;
      instr_q       <= '0;
      instr_ready_q <= 1'b0;
      scan_done_q   <= 1'b0;
`ifdef VSLC_SEQ_STEP_EN
      done_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wptr_q        <= wptr_d;
      prog_len_q    <= prog_len_d;
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      instr_q       <= instr_d;
      instr_ready_q <= instr_ready_d;
      scan_done_q   <= scan_done_d;
`ifdef VSLC_SEQ_STEP_EN
      done_q        <= done_d;
`endif
    end
  end

  // instr/instr_ready/scan_done are registered on the edge that enters the
  // cycle they describe, so instr_ready is high exactly in ISSUE cycles.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wptr_d        = wptr_q;
    prog_len_d    = prog_len_q;
    snap_d        = snap_q;
    prev_d        = prev_q;
    instr_d       = instr_q;
    instr_ready_d = 1'b0;
    scan_done_d   = 1'b0;
    rd_addr       = pc_q;
`ifdef VSLC_SEQ_STEP_EN
    done_d        = done_q;
`endif

    if (bus.mode_load) begin
      state_d = ST_LOAD;
      pc_d    = '0;
      if (state_q != ST_LOAD) begin
        wptr_d = '0;
      end else begin
        wptr_d = wptr_q + LW'(load_accept);
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.run_en && (prog_len_q != '0)) begin
            state_d = ST_SCAN_START;
          end
        end
        ST_LOAD: begin
          wptr_d     = wptr_q + LW'(load_accept);
          prog_len_d = wptr_d;
          state_d    = ST_IDLE;
        end
        ST_SCAN_START: begin
          prev_d  = snap_q;
          snap_d  = bus.ui_in;
          pc_d    = '0;
          state_d = ST_ISSUE;
`ifdef VSLC_SEQ_STEP_EN
          done_d  = 1'b0;
`else
          rd_addr       = '0;
          instr_d       = rd_data;
          instr_ready_d = 1'b1;
`endif
        end
        ST_ISSUE: begin
`ifdef VSLC_SEQ_STEP_EN
          // The last issue stays in ISSUE for its instr_ready cycle; done_q
          // then moves on to SCAN_END without waiting for another step.
          if (done_q) begin
            state_d     = ST_SCAN_END;
            scan_done_d = 1'b1;
          end else if (bus.step) begin
            rd_addr       = pc_q;
            instr_d       = rd_data;
            instr_ready_d = 1'b1;
            if (last_c) begin
              done_d = 1'b1;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
`else
          if (!last_c) begin
            pc_d          = pc_q + AW'(1);
            rd_addr       = pc_q + AW'(1);
            instr_d       = rd_data;
            instr_ready_d = 1'b1;
          end else begin
            state_d     = ST_SCAN_END;
            scan_done_d = 1'b1;
          end
`endif
        end
        ST_SCAN_END: begin
          state_d = bus.run_en ? ST_SCAN_START : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready  = (state_q == ST_LOAD) && (wptr_q < DEPTH_L);
  assign bus.ui_in_snap  = snap_q;
  assign bus.ui_in_prev  = prev_q;
  assign bus.instr       = instr_q;
  assign bus.instr_ready = instr_ready_q;
  assign bus.pc          = pc_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.scan_done   = scan_done_q;

endmodule

// File: tb/tb_vslc_sequencer.sv
// tb/tb_vslc_sequencer.sv - self-checking bench for vslc_sequencer

module tb_vslc_sequencer;
  import vslc_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vslc_sequencer_if #(.PROG_DEPTH(DEPTH)) bus ();

  vslc_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]    instr;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && bus.instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_issue: instr 0x%0h pc %0d with nothing expected", bus.instr, bus.pc);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_instr", 32'(bus.instr), 32'(sb_e.instr));
        check("sb_pc", 32'(bus.pc), 32'(sb_e.pc));
      end
    end
  end

  typedef struct {
    int         n;
    logic [7:0] b [12];
    logic [7:0] ui1;
    logic [7:0] ui2;
    int         exp_len;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n, input logic [7:0] b [12], input int exp_len);
    tick();
    bus.mode_load  = 1'b1;
    bus.load_valid = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = b[i];
      @(negedge clk);
      check("load_ready", 32'(bus.load_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.mode_load  = 1'b0;
    tick();
    @(negedge clk);
    check("prog_len", 32'(bus.prog_len), 32'(exp_len));
    check("load_ready_idle", 32'(bus.load_ready), 32'd0);
  endtask

  task automatic wait_scan_done();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.scan_done) break;
    end
    check("scan_done_seen", 32'(bus.scan_done), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_prog_len", 32'(bus.prog_len), 32'd0);
    check("rst_snap", 32'(bus.ui_in_snap), 32'd0);
    check("rst_prev", 32'(bus.ui_in_prev), 32'd0);
    check("rst_scan_done", 32'(bus.scan_done), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] last_snap;
  logic [7:0] prog0 [12];
  int         exp_rdy  [8];
  int         exp_done [8];
  logic [7:0] exp_ins  [8];

  initial begin
    bus.mode_load  = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.run_en     = 1'b0;
    bus.ui_in      = 8'h00;
`ifdef VSLC_SEQ_STEP_EN
    bus.step       = 1'b0;
`endif

    vecs[0] = '{3,  '{8'h01, 8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h0F, 8'hF0, 3};
    vecs[1] = '{1,  '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h33, 8'hCC, 1};
    vecs[2] = '{5,  '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                8'h00, 8'hFF, 5};
    vecs[3] = '{11, '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B},
                8'h5A, 8'hA5, DEPTH};
    prog0 = vecs[0].b;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;

    // Table: load, run two scans (run_en dropped mid-scan 2), check snapshots
    last_snap = 8'h00;
    sb_on = 1'b1;
    for (int v = 0; v < 4; v++) begin
      load_prog(vecs[v].n, vecs[v].b, vecs[v].exp_len);
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < vecs[v].exp_len; i++) begin
          sb_q.push_back('{vecs[v].b[i], AW'(i)});
        end
      end
      bus.ui_in  = vecs[v].ui1;
      bus.run_en = 1'b1;
      wait_scan_done();
      check("snap_scan1", 32'(bus.ui_in_snap), 32'(vecs[v].ui1));
      check("prev_scan1", 32'(bus.ui_in_prev), 32'(last_snap));
      tick();
      bus.run_en = 1'b0;
      bus.ui_in  = vecs[v].ui2;
      wait_scan_done();
      check("snap_scan2", 32'(bus.ui_in_snap), 32'(vecs[v].ui2));
      check("prev_scan2", 32'(bus.ui_in_prev), 32'(vecs[v].ui1));
      repeat (5) tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      last_snap = vecs[v].ui2;
    end
    sb_on = 1'b0;
    sb_q.delete();

`ifndef VSLC_SEQ_STEP_EN
    // Exact latency and scan period for a 3-byte program
    load_prog(3, prog0, 3);
    exp_rdy  = '{0, 0, 1, 1, 1, 0, 0, 1};
    exp_done = '{0, 0, 0, 0, 0, 1, 0, 0};
    exp_ins  = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h10, 8'h00, 8'h00, 8'h01};
    bus.run_en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rdy_N+%0d", k), 32'(bus.instr_ready), 32'(exp_rdy[k]));
      check($sformatf("done_N+%0d", k), 32'(bus.scan_done), 32'(exp_done[k]));
      if (exp_rdy[k] != 0) begin
        check($sformatf("instr_N+%0d", k), 32'(bus.instr), 32'(exp_ins[k]));
      end
    end

    // mode_load during the second issue aborts the scan
    tick();
    bus.mode_load = 1'b1;
    @(negedge clk);
    check("issue2_rdy", 32'(bus.instr_ready), 32'd1);
    check("issue2_instr", 32'(bus.instr), 32'h80);
    tick();
    @(negedge clk);
    check("abort_rdy", 32'(bus.instr_ready), 32'd0);
    check("abort_pc", 32'(bus.pc), 32'd0);
    check("abort_in_load", 32'(bus.load_ready), 32'd1);
    repeat (3) begin
      tick();
      check("load_no_issue", 32'(bus.instr_ready), 32'd0);
    end
    bus.mode_load = 1'b0;
    tick();
    @(negedge clk);
    check("empty_prog_len", 32'(bus.prog_len), 32'd0);
    repeat (10) begin
      tick();
      check("empty_no_issue", 32'(bus.instr_ready), 32'd0);
    end
    bus.run_en = 1'b0;
`else
    // Single-step: no issue without step, one issue per step pulse
    load_prog(3, prog0, 3);
    bus.step   = 1'b0;
    bus.run_en = 1'b1;
    repeat (10) begin
      tick();
      check("step0_no_issue", 32'(bus.instr_ready), 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      @(negedge clk);
      check("step_rdy", 32'(bus.instr_ready), 32'd1);
      check("step_instr", 32'(bus.instr), 32'(prog0[k]));
      repeat (3) begin
        tick();
        check("step_hold", 32'(bus.instr_ready), 32'd0);
      end
    end
    bus.run_en = 1'b0;
`endif

    // Reset mid-scan aborts without scan_done
    load_prog(3, prog0, 3);
`ifdef VSLC_SEQ_STEP_EN
    bus.step = 1'b1;
`endif
    bus.run_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    bus.run_en = 1'b0;
`ifdef VSLC_SEQ_STEP_EN
    bus.step   = 1'b0;
`endif
    @(negedge clk);
    check_reset_outputs();
    repeat (8) begin
      tick();
      check("no_done_after_rst", 32'(bus.scan_done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
